pool_tile_loader: RTL and testbench
===================================

// Module: pool_tile_loader
// PURPOSE
//  Upstream feeder for the multi-channel average-pool stage. Accepts a valid/ready pixel stream, all
//  CHANNEL_COUNT channels in parallel per beat, row-major. Assembles one MAT_DIMENSION x MAT_DIMENSION
//  tile per channel and holds it stable on mat_out_y. Sequences the pool's reset and waits for every
//  channel's finished flag before releasing the tile.
// PARAMETERS
//  DATAWIDTH      32  bits per element (IEEE-754 single in current datapath)
//  MAT_DIMENSION  2   tile side; tile = MAT_DIMENSION^2 beats
//  CHANNEL_COUNT  1   parallel channels per beat
// PORTS
//  clk            in   1                              rising-edge clock
//  rst            in   1                              async, active-low reset
//  in_data        in   DATAWIDTH x [CHANNEL_COUNT]    one pixel per channel
//  in_valid       in   1                              beat offered
//  in_ready       out  1                              beat accepted when in_valid & in_ready
//  mat_out_y      out  DATAWIDTH x [CH][DIM][DIM]     tile to pool stage
//  pool_rst       out  1                              active-high reset to pool stage
//  pool_finished  in   1 x [CHANNEL_COUNT]            per-channel finished from pool stage
//  tile_done      out  1                              1-cycle pulse: pool finished current tile
//  busy           out  1                              high in RUN or DONE
// BEHAVIOUR
//  Reset (rst=0, async): state=FILL, row/col counters=0, mat_out_y all 0, pool_rst=1,
//    tile_done=0, busy=0, in_ready=1 after release.
//  FILL: in_ready=1, pool_rst=1. Each accepted beat writes in_data[c] to mat[c][row][col].
//    col increments; on wrap col=0, row++. Last beat (row=col=DIM-1) -> RUN next cycle, counters to 0.
//  RUN: pool_rst=0, in_ready=0, busy=1, mat_out_y frozen. pool_finished is ignored in the first
//    RUN cycle (stale). When all CHANNEL_COUNT finished bits are 1 -> DONE.
//  DONE: one cycle. tile_done=1, pool_rst=1, busy=1 -> FILL (or RUN, see CONFIGURATION).
//  Latency: last beat accepted at cycle t -> pool_rst falls at t+1. tile_done is asserted one cycle
//    after the cycle in which all finished bits are first seen high.
//  Partial finished (some channels high): stay in RUN; no timeout.
//  in_valid=0 mid-tile: counters hold; no bubble limit.
//  MAT_DIMENSION=1: each beat is a full tile.
//  Reset mid-tile or mid-RUN: partial tile discarded, return to reset state.
//  Counters are $clog2(MAT_DIMENSION) bits wide, minimum 1. No arithmetic is performed on data.
// CONFIGURATION
//  TILE_DOUBLE_BUFFER_EN defined: adds a shadow tile buffer.
//    - In RUN/DONE, in_ready=1 until the shadow buffer holds a full tile; beats fill the shadow.
//    - DONE with a full shadow: copy shadow -> mat_out_y on the DONE->RUN edge.
//      Go directly to RUN; pool_rst is high exactly one cycle (the DONE cycle).
//    - DONE with shadow partial/empty: go to FILL; the filled portion is moved to the active
//      buffer and counters continue, so no beats are lost.
//  TILE_DOUBLE_BUFFER_EN undefined: single buffer; in_ready=0 throughout RUN and DONE.
// TESTING
//  1 DIM=2, CH=1: beats 1.0,2.0,3.0,4.0 (0x3f800000..0x40800000), then finished=1 two cycles later
//    -> mat_out_y=[[1,2],[3,4]]; pool_rst 1->0 the cycle after the 4th beat; one tile_done pulse.
//  2 CH=3: finished bits rise at different cycles (ch0 t+2, ch2 t+5, ch1 t+7)
//    -> tile_done only at t+8; in_ready=0 throughout.
//  3 in_valid toggled 1,0,0,1,1,0,1 -> exactly 4 beats captured in order; no extra writes.
//  4 Assert rst=0 after 3 of 4 beats, release, stream 4 new beats
//    -> tile contains only the new beats; tile_done count=1.
//  5 finished held high entering RUN (stale)
//    -> no tile_done in the first RUN cycle; tile_done follows the second RUN cycle.
//  6 TILE_DOUBLE_BUFFER_EN: continuous stream of 3 tiles
//    -> tiles 2 and 3 accepted during RUN; pool_rst pulses exactly 1 cycle between tiles;
//       3 tile_done pulses; data order preserved.

Source files
------------

// File: rtl/pool_tile_loader.sv
// pool_tile_loader: gathers one MAT_DIMENSION x MAT_DIMENSION tile per channel from a valid/ready
// stream, holds it for the pool stage and sequences pool_rst. Optional macro: TILE_DOUBLE_BUFFER_EN.
module pool_tile_loader #(
  parameter int DATAWIDTH     = 32,
  parameter int MAT_DIMENSION = 2,
  parameter int CHANNEL_COUNT = 1
) (
  input  logic                                                                      clk,
  input  logic                                                                      rst,
  input  logic [CHANNEL_COUNT-1:0][DATAWIDTH-1:0]                                   in_data,
  input  logic                                                                      in_valid,
  output logic                                                                      in_ready,
  output logic [CHANNEL_COUNT-1:0][MAT_DIMENSION-1:0][MAT_DIMENSION-1:0][DATAWIDTH-1:0] mat_out_y,
  output logic                                                                      pool_rst,
  input  logic [CHANNEL_COUNT-1:0]                                                  pool_finished,
  output logic                                                                      tile_done,
  output logic                                                                      busy
);
  localparam int CW = (MAT_DIMENSION > 1) ? $clog2(MAT_DIMENSION) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(MAT_DIMENSION - 1);

  typedef logic [CHANNEL_COUNT-1:0][MAT_DIMENSION-1:0][MAT_DIMENSION-1:0][DATAWIDTH-1:0] tile_t;
  typedef enum logic [1:0] {FILL = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] row_q, row_d, col_q, col_d, row_nx, col_nx;
  tile_t         mat_q, mat_d;
  logic          first_q, first_d;
  logic          in_ready_q, in_ready_d;
  logic          pool_rst_q, pool_rst_d;
  logic          tile_done_q, tile_done_d;
  logic          busy_q, busy_d;
  logic          accept, last_beat, all_fin;
`ifdef TILE_DOUBLE_BUFFER_EN
  tile_t         shadow_q, shadow_d;
  logic          shadow_full_q, shadow_full_d;
`endif

  assign accept    = in_valid & in_ready_q;
  assign last_beat = (row_q == LAST_IDX) && (col_q == LAST_IDX);
  assign all_fin   = &pool_finished;

  // Raster position that follows the current one
  always_comb begin
    row_nx = row_q;
    col_nx = col_q;
    if (col_q == LAST_IDX) begin
      col_nx = {CW{1'b0}};
      if (row_q == LAST_IDX) begin
        row_nx = {CW{1'b0}};
      end else begin
        row_nx = row_q + CW'(1);
      end
    end else begin
      col_nx = col_q + CW'(1);
    end
  end

  // Tile assembly and FILL/RUN/DONE sequencing
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    mat_d   = mat_q;
    first_d = 1'b0;
`ifdef TILE_DOUBLE_BUFFER_EN
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    // Beats arriving while the pool works land in the shadow tile
    if (accept && (state_q != FILL)) begin
      for (int c = 0; c < CHANNEL_COUNT; c++) begin
        shadow_d[c][row_q][col_q] = in_data[c];
      end
      row_d         = row_nx;
      col_d         = col_nx;
      shadow_full_d = last_beat;
    end else begin
      shadow_full_d = shadow_full_q;
    end
`endif
    case (state_q)
      FILL: begin
        if (accept) begin
          for (int c = 0; c < CHANNEL_COUNT; c++) begin
            mat_d[c][row_q][col_q] = in_data[c];
          end
          row_d = row_nx;
          col_d = col_nx;
          if (last_beat) begin
            state_d = RUN;
            first_d = 1'b1;
          end else begin
            state_d = FILL;
          end
        end else begin
          state_d = FILL;
        end
      end
      RUN: begin
        // finished seen in the first RUN cycle still belongs to the previous tile
        if (!first_q && all_fin) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
`ifdef TILE_DOUBLE_BUFFER_EN
        mat_d = shadow_d;
        if (shadow_full_d) begin
          state_d       = RUN;
          first_d       = 1'b1;
          shadow_full_d = 1'b0;
        end else begin
          state_d = FILL;
        end
`else
        state_d = FILL;
`endif
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // Output values for the next cycle, decoded from the next state
  always_comb begin
    pool_rst_d  = (state_d != RUN);
    tile_done_d = (state_d == DONE);
    busy_d      = (state_d != FILL);
`ifdef TILE_DOUBLE_BUFFER_EN
    in_ready_d  = !shadow_full_d;
`else
    in_ready_d  = (state_d == FILL);
`endif
  end

  // State, counters, active tile and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FILL;
      row_q       <= {CW{1'b0}};
      col_q       <= {CW{1'b0}};
      mat_q       <= '0;
      first_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      pool_rst_q  <= 1'b1;
      tile_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      mat_q       <= mat_d;
      first_q     <= first_d;
      in_ready_q  <= in_ready_d;
      pool_rst_q  <= pool_rst_d;
      tile_done_q <= tile_done_d;
      busy_q      <= busy_d;
    end
  end

`ifdef TILE_DOUBLE_BUFFER_EN
  // Shadow tile storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
    end else begin
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
    end
  end
`endif

  assign in_ready  = in_ready_q;
  assign mat_out_y = mat_q;
  assign pool_rst  = pool_rst_q;
  assign tile_done = tile_done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_pool_tile_loader.sv
// Self-checking bench for pool_tile_loader: directed and randomized tiles checked against a
// beat-queue reference model; a second DIM=1 instance covers the one-beat-tile case.
module tb_pool_tile_loader;
  localparam int DW  = 32;
  localparam int DIM = 2;
  localparam int CH  = 3;
`ifdef TILE_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  typedef logic [CH-1:0][DW-1:0] pix_t;
  typedef logic [CH-1:0][DIM-1:0][DIM-1:0][DW-1:0] tile_t;

  logic        clk = 1'b0;
  logic        rst;
  pix_t        in_data;
  logic        in_valid, in_ready;
  tile_t       mat_out_y;
  logic        pool_rst;
  logic [CH-1:0] pool_finished;
  logic        tile_done, busy;

  logic [0:0][DW-1:0]             d1_data;
  logic                           d1_valid, d1_ready;
  logic [0:0][0:0][0:0][DW-1:0]   d1_mat;
  logic                           d1_prst;
  logic [0:0]                     d1_fin;
  logic                           d1_done, d1_busy;

  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   tiles_run = 0;
  pix_t beats[$];

  pool_tile_loader #(.DATAWIDTH(DW), .MAT_DIMENSION(DIM), .CHANNEL_COUNT(CH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mat_out_y(mat_out_y), .pool_rst(pool_rst), .pool_finished(pool_finished),
    .tile_done(tile_done), .busy(busy)
  );

  pool_tile_loader #(.DATAWIDTH(DW), .MAT_DIMENSION(1), .CHANNEL_COUNT(1)) dut_d1 (
    .clk(clk), .rst(rst), .in_data(d1_data), .in_valid(d1_valid), .in_ready(d1_ready),
    .mat_out_y(d1_mat), .pool_rst(d1_prst), .pool_finished(d1_fin),
    .tile_done(d1_done), .busy(d1_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tile_done === 1'b1) done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_tile(input string tag, input tile_t obs, input tile_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic pix_t rand_pix();
    pix_t p;
    for (int c = 0; c < CH; c++) p[c] = $urandom();
    return p;
  endfunction

  // Reference: beat i of a tile goes to row i/DIM, column i%DIM, all channels alike
  function automatic tile_t tile_of(input int base);
    tile_t t;
    for (int i = 0; i < DIM * DIM; i++)
      for (int c = 0; c < CH; c++)
        t[c][i / DIM][i % DIM] = beats[base + i][c];
    return t;
  endfunction

  task automatic send_beat(input pix_t d);
    int n;
    n = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk("fill_in_ready", in_ready, 1'b1);
    chk("fill_pool_rst", pool_rst, 1'b1);
    step();
    beats.push_back(d);
    in_valid = 1'b0;
  endtask

  task automatic send_tile(input int max_gap);
    for (int i = 0; i < DIM * DIM; i++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, max_gap)) step();
      send_beat(rand_pix());
    end
  endtask

  // Called in the cycle after the last beat; channel c reports finished from cycle t+dly[c]
  task automatic run_pool(input int d0, input int d1, input int d2);
    int    dly[CH];
    int    m;
    int    exp_k;
    tile_t exp_t;
    dly = '{d0, d1, d2};
    m = 2;
    foreach (dly[c]) if (dly[c] > m) m = dly[c];
    exp_k = m + 1;
    exp_t = tile_of(beats.size() - DIM * DIM);
    for (int k = 1; k <= exp_k + 1; k++) begin
      chk("tile_done", tile_done, (k == exp_k));
      chk("pool_rst", pool_rst, (k >= exp_k));
      chk("busy", busy, (k <= exp_k));
      chk("in_ready_run", in_ready, DB ? 1'b1 : (k > exp_k));
      if (k <= exp_k) chk_tile("tile_hold", mat_out_y, exp_t);
      for (int c = 0; c < CH; c++) pool_finished[c] = (k >= dly[c]);
      step();
    end
    pool_finished = '0;
    tiles_run++;
  endtask

  initial begin
    pix_t  d;
    tile_t zero_t;
    int    vpat[7];
    int    cnt0;
    logic [DW-1:0] one_val;
`ifdef TILE_DOUBLE_BUFFER_EN
    int    base, ndone, run_len, cyc;
    bit    prev_done;
`endif
    zero_t        = '0;
    vpat          = '{1, 0, 0, 1, 1, 0, 1};
    rst           = 1'b0;
    in_data       = '0;
    in_valid      = 1'b0;
    pool_finished = '0;
    d1_data       = '0;
    d1_valid      = 1'b0;
    d1_fin        = '0;

    // Reset state
    #12;
    chk("rst_pool_rst", pool_rst, 1'b1);
    chk("rst_tile_done", tile_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk_tile("rst_mat", mat_out_y, zero_t);
    #10 rst = 1'b1;
    step();
    chk("rel_in_ready", in_ready, 1'b1);

    // One-element tile: every beat starts a pool run
    one_val  = $urandom();
    d1_data  = one_val;
    d1_valid = 1'b1;
    chk("d1_ready", d1_ready, 1'b1);
    step();
    d1_valid = 1'b0;
    chk("d1_pool_rst", d1_prst, 1'b0);
    chk("d1_busy", d1_busy, 1'b1);
    chk("d1_mat", d1_mat[0][0][0], one_val);
    d1_fin = 1'b1;
    step();
    chk("d1_stale", d1_done, 1'b0);
    step();
    chk("d1_done", d1_done, 1'b1);
    d1_fin = 1'b0;
    step();
    chk("d1_done_end", d1_done, 1'b0);
    chk("d1_busy_end", d1_busy, 1'b0);

    // Float beats 1.0..4.0 on channel 0, finished two cycles after RUN starts
    d = rand_pix(); d[0] = 32'h3f800000; send_beat(d);
    d = rand_pix(); d[0] = 32'h40000000; send_beat(d);
    d = rand_pix(); d[0] = 32'h40400000; send_beat(d);
    d = rand_pix(); d[0] = 32'h40800000; send_beat(d);
    chk("t1_m00", mat_out_y[0][0][0], 32'h3f800000);
    chk("t1_m01", mat_out_y[0][0][1], 32'h40000000);
    chk("t1_m10", mat_out_y[0][1][0], 32'h40400000);
    chk("t1_m11", mat_out_y[0][1][1], 32'h40800000);
    run_pool(2, 2, 2);

    // Staggered per-channel finished
    send_tile(0);
    run_pool(2, 7, 5);

    // in_valid gaps: only valid cycles write
    for (int i = 0; i < 7; i++) begin
      d        = rand_pix();
      in_data  = d;
      in_valid = (vpat[i] != 0);
      if (vpat[i] != 0) begin
        chk("pat_in_ready", in_ready, 1'b1);
        beats.push_back(d);
      end
      step();
    end
    in_valid = 1'b0;
    run_pool(1, 1, 1);

    // Reset after three beats discards the partial tile
    for (int i = 0; i < 3; i++) send_beat(rand_pix());
    #2 rst = 1'b0;
    #1;
    chk_tile("midrst_mat", mat_out_y, zero_t);
    chk("midrst_pool_rst", pool_rst, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    beats.delete();
    step();
    rst = 1'b1;
    step();
    cnt0 = done_cnt;
    send_tile(0);
    run_pool(2, 3, 2);
    chk("midrst_done_cnt", done_cnt - cnt0, 1);

    // finished already high when RUN begins
    for (int i = 0; i < 3; i++) send_beat(rand_pix());
    pool_finished = '1;
    send_beat(rand_pix());
    run_pool(0, 0, 0);

    // Randomized tiles with bubbles and random finish delays
    for (int r = 0; r < 4; r++) begin
      send_tile(2);
      run_pool($urandom_range(1, 7), $urandom_range(1, 7), $urandom_range(1, 7));
    end

`ifdef TILE_DOUBLE_BUFFER_EN
    // Continuous stream of three tiles through the shadow buffer
    base      = beats.size();
    ndone     = 0;
    run_len   = 0;
    cyc       = 0;
    prev_done = 1'b0;
    fork
      begin
        pix_t dd;
        int   n;
        for (int i = 0; i < 3 * DIM * DIM; i++) begin
          dd       = rand_pix();
          n        = 0;
          in_data  = dd;
          in_valid = 1'b1;
          while (in_ready !== 1'b1 && n < 100) begin
            step();
            n++;
          end
          step();
          beats.push_back(dd);
        end
        in_valid = 1'b0;
      end
      begin
        while (cyc < 400 && !(ndone == 3 && !prev_done)) begin
          if (prev_done) chk("db_gap_pool_rst", pool_rst, (ndone == 3));
          prev_done = (tile_done === 1'b1);
          if (prev_done) begin
            chk_tile("db_tile", mat_out_y, tile_of(base + DIM * DIM * ndone));
            ndone++;
          end
          pool_finished = (busy && !pool_rst && run_len >= 5) ? '1 : '0;
          run_len = (busy && !pool_rst) ? run_len + 1 : 0;
          step();
          cyc++;
        end
      end
    join
    pool_finished = '0;
    chk("db_tiles", ndone, 3);
    tiles_run += 3;
`endif

    chk("done_total", done_cnt, tiles_run);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
